// File: rtl/pipe_latch_skid_if.sv
// Handshake and payload bundle for pipe_latch_skid: upstream valid/ready/data/ctrl,
// downstream valid/ready/data/ctrl, plus flush and the bubble-counter controls.
interface pipe_latch_skid_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) ();

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              clr_cnt;

    // Environment side: drives upstream entries, downstream ready and the controls.
    modport master (
        output flush,
        output in_valid,
        output in_data,
        output in_ctrl,
        output out_ready,
        output clr_cnt,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ctrl,
        input  bubble_cnt
    );

    // Latch side.
    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  in_ctrl,
        input  out_ready,
        input  clr_cnt,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ctrl,
        output bubble_cnt
    );

endinterface

// File: rtl/pipe_latch_skid.sv
// Reusable pipeline latch with a main/skid register pair, registered in_ready, synchronous
// flush to a NOP bubble and a saturating bubble counter.
module pipe_latch_skid #(
    parameter int unsigned DATA_W              = 32,
    parameter int unsigned CTRL_W              = 8,
    parameter int unsigned CNT_W               = 16,
    parameter bit          ZERO_DATA_ON_BUBBLE = 1'b0
) (
    input logic               clk,
    input logic               reset,
    pipe_latch_skid_if.slave  bus
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic out_valid;
    logic in_xfer;
    logic out_xfer;

    assign out_valid = (state_q != StEmpty);
    assign in_xfer   = bus.in_valid & in_ready_q & ~bus.flush;
    assign out_xfer  = out_valid & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (bus.flush) begin
            // Held payloads stay in place; the empty state alone turns them into bubbles.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d     = StOne;
                        main_data_d = bus.in_data;
                        main_ctrl_d = bus.in_ctrl;
                    end
                end
                StOne: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = bus.in_data;
                        main_ctrl_d = bus.in_ctrl;
                    end else if (in_xfer) begin
                        state_d     = StFull;
                        skid_data_d = bus.in_data;
                        skid_ctrl_d = bus.in_ctrl;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        state_d     = StOne;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        // Registered so upstream never sees a combinational path from out_ready.
        in_ready_d = (state_d != StFull);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (!out_valid && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_ctrl   = out_valid ? main_ctrl_q : '0;
    assign bus.out_data   = (ZERO_DATA_ON_BUBBLE && !out_valid) ? '0 : main_data_q;
    assign bus.bubble_cnt = cnt_q;

    a_bubble_nop: assert property (@(posedge clk) disable iff (reset)
        !out_valid |-> (bus.out_ctrl == '0));

    a_ready_tracks_state: assert property (@(posedge clk) disable iff (reset)
        in_ready_q == (state_q != StFull));

endmodule
